vector_lane_serializer: RTL and testbench

VECTOR_LANE_SERIALIZER -- requirements
Module: vector_lane_serializer

---
 rtl/vector_lane_serializer_pkg.sv | 12 +
 rtl/vector_lane_serializer_lane_select.sv | 18 +
 rtl/vector_lane_serializer.sv | 92 +++++++++
 tb/tb_vector_lane_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_lane_serializer_pkg.sv
// rtl/vector_lane_serializer_pkg.sv - shared lane geometry constants and FSM state type
package vector_lane_serializer_pkg;
    localparam int LANES  = 6;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/vector_lane_serializer_lane_select.sv
// rtl/vector_lane_serializer_lane_select.sv - combinational pick of one lane from a packed vector
module lane_select #(
    parameter int LANES  = vector_lane_serializer_pkg::LANES,
    parameter int LANE_W = vector_lane_serializer_pkg::LANE_W
) (
    input  logic [LANES*LANE_W-1:0]  vec,
    input  logic [$clog2(LANES)-1:0] idx,
    output logic [LANE_W-1:0]        lane
);
    always_comb begin
        lane = '0;
        for (int k = 0; k < LANES; k++) begin
            if (idx == k[$clog2(LANES)-1:0]) begin
                lane = vec[k*LANE_W +: LANE_W];
            end
        end
    end
endmodule

// File: rtl/vector_lane_serializer.sv
// rtl/vector_lane_serializer.sv - emits a registered multi-lane vector one lane per handshake
// VSER_REVERSE_EN: when defined, lanes go out from LANES-1 down to 0.
module vector_lane_serializer #(
    parameter int LANES  = vector_lane_serializer_pkg::LANES,
    parameter int LANE_W = vector_lane_serializer_pkg::LANE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W-1:0]        out_data,
    output logic [$clog2(LANES)-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy
);
    import vector_lane_serializer_pkg::*;

    localparam int IW = $clog2(LANES);

`ifdef VSER_REVERSE_EN
    localparam logic [IW-1:0] FIRST_IDX = IW'(LANES - 1);
    localparam logic [IW-1:0] LAST_IDX  = '0;
`else
    localparam logic [IW-1:0] FIRST_IDX = '0;
    localparam logic [IW-1:0] LAST_IDX  = IW'(LANES - 1);
`endif

    state_t                    state, state_nxt;
    logic [LANES*LANE_W-1:0]   vec_q;
    logic [IW-1:0]             cnt;
    logic                      accept;
    logic                      out_hs;

    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (out_hs && out_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is forced low during reset so nothing can be loaded while rst=0.
    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_last  = (state == SEND) && (cnt == LAST_IDX);
        in_ready  = rst && ((state == IDLE) || (out_last && out_ready));
    end

    // Vector only loads on acceptance; the counter stops at the final lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vec_q <= '0;
            cnt   <= '0;
        end else if (accept) begin
            vec_q <= in_vec;
            cnt   <= FIRST_IDX;
        end else if (out_hs && !out_last) begin
`ifdef VSER_REVERSE_EN
            cnt <= cnt - 1'b1;
`else
            cnt <= cnt + 1'b1;
`endif
        end
    end

    lane_select #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .vec  (vec_q),
        .idx  (cnt),
        .lane (out_data)
    );

    assign out_idx = cnt;
endmodule

// File: tb/tb_vector_lane_serializer.sv
// tb/tb_vector_lane_serializer.sv - directed self-checking bench for vector_lane_serializer
module tb_vector_lane_serializer;
    localparam int LANES  = 6;
    localparam int LANE_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*LANE_W-1:0] in_vec;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANE_W-1:0]       out_data;
    logic [2:0]              out_idx;
    logic                    out_last;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    logic [LANES*LANE_W-1:0] v_basic;
    logic [LANES*LANE_W-1:0] v_a0;
    logic [LANES*LANE_W-1:0] v_bp;
    logic [LANES*LANE_W-1:0] v_junk;

    always #5 clk = ~clk;

    vector_lane_serializer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic int lane_at(input int i);
`ifdef VSER_REVERSE_EN
        return LANES - 1 - i;
`else
        return i;
`endif
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input logic [LANES*LANE_W-1:0] v, input int k);
        return v[k*LANE_W +: LANE_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_vec = v_basic; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b busy=%b expected 0 0 0",
                         c, in_ready, out_valid, busy);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (out_data !== 32'h0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: data=%h idx=%0d last=%b expected 0 0 0", out_data, out_idx, out_last);
        end
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        in_vec = v_basic; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== lane_of(v_basic, lane_at(i)) ||
                out_idx !== 3'(lane_at(i)) || out_last !== (i == LANES - 1)) begin
                bad++;
                $display("FAIL basic_lane %0d: valid=%b data=%h idx=%0d last=%b expected 1 %h %0d %b",
                         i, out_valid, out_data, out_idx, out_last,
                         lane_of(v_basic, lane_at(i)), lane_at(i), (i == LANES - 1));
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_done: busy=%b out_valid=%b in_ready=%b expected 0 0 1", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        logic stalled = 1'b0;
        logic [LANE_W-1:0] prev_data = '0;
        logic [2:0] prev_idx = '0;
        tick();
        in_vec = v_bp; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c % 3 == 0);
            @(negedge clk);
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_idx !== prev_idx) begin
                    bad++;
                    $display("FAIL bp_stable cycle %0d: valid=%b data=%h idx=%0d expected 1 %h %0d",
                             c, out_valid, out_data, out_idx, prev_data, prev_idx);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_idx !== 3'(lane_at(hs)) || out_data !== 32'h80000001 || out_last !== (hs == LANES - 1)) begin
                    bad++;
                    $display("FAIL bp_handshake %0d: idx=%0d data=%h last=%b expected %0d 80000001 %b",
                             hs, out_idx, out_data, out_last, lane_at(hs), (hs == LANES - 1));
                end
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
            end
            prev_data = out_data;
            prev_idx  = out_idx;
            tick();
        end
        @(negedge clk);
        total++;
        if (hs != LANES || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_count: handshakes=%0d busy=%b expected %0d 0", hs, busy, LANES);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        tick();
        in_vec = v_basic; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= 1 && i <= 4) begin
                in_vec = v_junk; in_valid = 1'b1;
            end else if (i == LANES - 1) begin
                in_vec = v_a0; in_valid = 1'b1;
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== lane_of(v_basic, lane_at(i)) ||
                in_ready !== (i == LANES - 1)) begin
                bad++;
                $display("FAIL b2b_first lane %0d: valid=%b data=%h in_ready=%b expected 1 %h %b",
                         i, out_valid, out_data, in_ready, lane_of(v_basic, lane_at(i)), (i == LANES - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== lane_of(v_a0, lane_at(i)) || out_idx !== 3'(lane_at(i))) begin
                bad++;
                $display("FAIL b2b_second lane %0d: valid=%b data=%h idx=%0d expected 1 %h %0d",
                         i, out_valid, out_data, out_idx, lane_of(v_a0, lane_at(i)), lane_at(i));
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        in_vec = v_basic; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_held: out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL midreset_idle cycle %0d: out_valid=%b in_ready=%b expected 0 1", c, out_valid, in_ready);
            end
            tick();
        end
        in_vec = v_a0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== lane_of(v_a0, lane_at(0)) || out_idx !== 3'(lane_at(0))) begin
            bad++;
            $display("FAIL midreset_resume: valid=%b data=%h idx=%0d expected 1 %h %0d",
                     out_valid, out_data, out_idx, lane_of(v_a0, lane_at(0)), lane_at(0));
        end
        for (int i = 0; i < LANES; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < LANES; k++) begin
            v_basic[k*LANE_W +: LANE_W] = 32'h11111111 * (k + 1);
            v_a0[k*LANE_W +: LANE_W]    = 32'hA0 + k;
            v_bp[k*LANE_W +: LANE_W]    = 32'h80000001;
            v_junk[k*LANE_W +: LANE_W]  = 32'hDEAD0000 + k;
        end
        rst = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
